vga_sync_handler: RTL and testbench
===================================

// Module: vga_sync_handler
// PURPOSE
//  VGA 640x480@60Hz timing generator. Divides the system clock (100 MHz) by 4 into a 25 MHz pixel rate;
//  runs horizontal/vertical position counters; emits hsync, vsync, display-enable and current pixel position.
//  Sits between the system clock and the pixel/colour generator (e.g. Pong renderer), which uses h/v spot.
// PARAMETERS
//  CLK_DIV    4    system clocks per pixel (power of 2, >=2)
//  H_DISPLAY  640  visible pixels per line
//  H_FRONT    16   h front porch (pixels)
//  H_SYNC     96   h sync width (pixels)
//  H_BACK     48   h back porch; H_TOTAL = 800
//  V_DISPLAY  480  visible lines per frame
//  V_FRONT    10   v front porch (lines)
//  V_SYNC     2    v sync width (lines)
//  V_BACK     33   v back porch; V_TOTAL = 525
// PORTS
//  i_clock        in   1   system clock, 100 MHz; all state on rising edge
//  i_reset        in   1   asynchronous, active-low reset
//  o_display_on   out  1   1 while position is inside the 640x480 visible area
//  o_hsync        out  1   horizontal sync, active low
//  o_vsync        out  1   vertical sync, active low
//  o_pixel_clock  out  1   25 MHz square wave, 50% duty (divider MSB)
//  o_h_spot       out  10  horizontal counter, 0..799
//  o_v_spot       out  10  vertical counter, 0..524
// BEHAVIOUR
//  - Reset (i_reset=0, async): divider=0, h=0, v=0 -> o_pixel_clock=0, o_h_spot=0, o_v_spot=0,
//    o_display_on=1, o_hsync=1, o_vsync=1. Reset mid-frame aborts immediately; restart from (0,0).
//  - Divider: free-running mod-CLK_DIV counter; tick = (div==CLK_DIV-1). o_pixel_clock = div[MSB]
//    (low 2 clocks, high 2 clocks); its falling edge coincides with the position update.
//  - On tick: h <= (h==799) ? 0 : h+1; when h wraps, v <= (v==524) ? 0 : v+1. No change off tick.
//  - Line = 800 pixels = 3200 clocks (32 us); frame = 525 lines = 1,680,000 clocks (16.8 ms).
//  - Decode is combinational from the h/v registers (zero latency vs o_h_spot/o_v_spot):
//    o_display_on = (h<640)&&(v<480); o_hsync = !(656<=h<=751); o_vsync = !(490<=v<=491).
//  - Counters never exceed H_TOTAL-1 / V_TOTAL-1; no overflow states reachable.
// CONFIGURATION
//  VGA_SYNC_ACTIVE_HIGH_EN: defined -> o_hsync/o_vsync active high (1 only inside the sync windows,
//  reset value 0). Undefined (default) -> active-low sync as above. No other behaviour changes.
// STRUCTURE
//  - Package vga_timing_pkg: H_/V_ DISPLAY/FRONT/SYNC/BACK/TOTAL localparams, derived sync start/end,
//    position width (10 bits).
//  - Sub-module vga_clk_div: mod-CLK_DIV divider producing pixel tick + o_pixel_clock.
//  - Top holds h/v counters and combinational sync/enable decode.
// TESTING
//  1. Hold i_reset=0 200 us, 100 MHz clock -> all outputs stay at reset values (0,0,1,1,1,0).
//  2. Release reset -> o_pixel_clock period 40 ns, 50% duty; o_h_spot increments every 4 clocks.
//  3. Run one line -> o_hsync low exactly for h=656..751 (384 clocks); h wraps 799->0, v 0->1.
//  4. Run one frame -> o_vsync low for v=490..491 (6400 clocks); v wraps 524->0 after 1,680,000 clocks.
//  5. Sample (639,479)->display_on=1; (640,0)->0; (0,480)->0.
//  6. Assert i_reset mid-line at h=300,v=200 -> outputs return to reset values asynchronously;
//     restart counts from (0,0); rebuild with VGA_SYNC_ACTIVE_HIGH_EN -> sync polarities inverted.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants for the 640x480@60Hz VGA generator.
//   - Horizontal/vertical display, porch, sync and total lengths.
//   - Derived first/last positions of the sync windows.
//   - Position width (10 bits covers 0..799 and 0..524).
//   - in_window(): inclusive range test used by the sync decode.
// These values are the defaults; the top exposes them as parameters so a
// reduced raster can be built for bring-up.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int CLK_DIV      = 4;

    localparam int H_DISPLAY    = 640;
    localparam int H_FRONT      = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BACK       = 48;
    localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

    localparam int V_DISPLAY    = 480;
    localparam int V_FRONT      = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BACK       = 33;
    localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int POS_W        = 10;

    typedef logic [POS_W-1:0] pos_t;

    // Inclusive window test: first <= pos <= last.
    function automatic logic in_window(input pos_t pos, input pos_t first, input pos_t last);
        return (pos >= first) && (pos <= last);
    endfunction

endpackage

// File: rtl/vga_clk_div.sv
// ---------------------------------------------------------------------------
// vga_clk_div
// Free-running mod-CLK_DIV counter that turns the system clock into the
// pixel rate.
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset (counter -> 0)
//   tick         out  1 for one system clock when the counter is at CLK_DIV-1;
//                     the position counters advance on this cycle
//   pixel_clock  out  counter MSB: low for the first half of a pixel period,
//                     high for the second half, so its falling edge lines up
//                     with the position update
// CLK_DIV must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module vga_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick,
    output logic pixel_clock
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign tick        = (div == DIV_LAST);
    assign pixel_clock = div[DIV_W-1];

endmodule

// File: rtl/vga_sync_handler.sv
// ---------------------------------------------------------------------------
// vga_sync_handler
// VGA 640x480@60Hz timing generator. A 100 MHz system clock is divided down
// to the 25 MHz pixel rate; horizontal and vertical position counters run at
// that rate and hsync / vsync / display-enable are decoded from them.
// Ports:
//   i_clock        in   system clock, all state on rising edge
//   i_reset        in   asynchronous active-low reset
//   o_display_on   out  1 while (h,v) is inside the visible area
//   o_hsync        out  horizontal sync
//   o_vsync        out  vertical sync
//   o_pixel_clock  out  pixel-rate square wave, 50% duty
//   o_h_spot       out  horizontal position, 0..H_TOTAL-1
//   o_v_spot       out  vertical position, 0..V_TOTAL-1
// Build option:
//   VGA_SYNC_ACTIVE_HIGH_EN  defined   -> hsync/vsync are 1 only inside the
//                                         sync windows (reset value 0)
//                            undefined -> hsync/vsync active low (reset value 1)
// All decode is combinational from the position registers, so the syncs and
// display enable line up with o_h_spot/o_v_spot with no extra latency.
// ---------------------------------------------------------------------------
module vga_sync_handler #(
    parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic       i_clock,
    input  logic       i_reset,
    output logic       o_display_on,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_pixel_clock,
    output logic [9:0] o_h_spot,
    output logic [9:0] o_v_spot
);

    import vga_timing_pkg::*;

    // Position constants at counter width so every compare is width-matched.
    localparam pos_t H_LAST    = pos_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam pos_t H_VIS_END = pos_t'(H_DISPLAY);
    localparam pos_t HS_FIRST  = pos_t'(H_DISPLAY + H_FRONT);
    localparam pos_t HS_LAST   = pos_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);

    localparam pos_t V_LAST    = pos_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam pos_t V_VIS_END = pos_t'(V_DISPLAY);
    localparam pos_t VS_FIRST  = pos_t'(V_DISPLAY + V_FRONT);
    localparam pos_t VS_LAST   = pos_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic pix_tick;
    pos_t h_pos;
    pos_t v_pos;
    logic hsync_on;
    logic vsync_on;

    vga_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk         (i_clock),
        .rst_n       (i_reset),
        .tick        (pix_tick),
        .pixel_clock (o_pixel_clock)
    );

    // Raster counters: h advances once per pixel tick; v advances only on
    // the tick where h wraps. Both wrap exactly at their last position, so
    // no out-of-range value can ever be loaded.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            h_pos <= '0;
            v_pos <= '0;
        end else if (pix_tick) begin
            if (h_pos == H_LAST) begin
                h_pos <= '0;
                if (v_pos == V_LAST) begin
                    v_pos <= '0;
                end else begin
                    v_pos <= v_pos + 1'b1;
                end
            end else begin
                h_pos <= h_pos + 1'b1;
            end
        end
    end

    assign hsync_on     = in_window(h_pos, HS_FIRST, HS_LAST);
    assign vsync_on     = in_window(v_pos, VS_FIRST, VS_LAST);
    assign o_display_on = (h_pos < H_VIS_END) && (v_pos < V_VIS_END);

`ifdef VGA_SYNC_ACTIVE_HIGH_EN
    assign o_hsync = hsync_on;
    assign o_vsync = vsync_on;
`else
    assign o_hsync = ~hsync_on;
    assign o_vsync = ~vsync_on;
`endif

    assign o_h_spot = h_pos;
    assign o_v_spot = v_pos;

endmodule

// File: tb/tb_vga_sync_handler.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_handler
// Two instances share clock and reset: dut_a uses the full 640x480 raster,
// dut_b a reduced 16x13 raster so whole frames (vertical wrap, vsync window,
// bottom of the visible area) fit in a short run.
// The expected output word for each instance is derived from the number of
// system clocks since reset release, pushed at each rising edge and popped
// and compared on the following falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_sync_handler;

    // Reduced raster for dut_b.
    localparam int S_HD = 8;
    localparam int S_HF = 2;
    localparam int S_HS = 3;
    localparam int S_HB = 3;
    localparam int S_VD = 6;
    localparam int S_VF = 2;
    localparam int S_VS = 2;
    localparam int S_VB = 3;

`ifdef VGA_SYNC_ACTIVE_HIGH_EN
    localparam logic SYNC_ON = 1'b1;
`else
    localparam logic SYNC_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic       a_de, a_hs, a_vs, a_pc;
    logic [9:0] a_h, a_v;
    logic       b_de, b_hs, b_vs, b_pc;
    logic [9:0] b_h, b_v;

    vga_sync_handler dut_a (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .o_display_on  (a_de),
        .o_hsync       (a_hs),
        .o_vsync       (a_vs),
        .o_pixel_clock (a_pc),
        .o_h_spot      (a_h),
        .o_v_spot      (a_v)
    );

    vga_sync_handler #(
        .CLK_DIV   (4),
        .H_DISPLAY (S_HD), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_DISPLAY (S_VD), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB)
    ) dut_b (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .o_display_on  (b_de),
        .o_hsync       (b_hs),
        .o_vsync       (b_vs),
        .o_pixel_clock (b_pc),
        .o_h_spot      (b_h),
        .o_v_spot      (b_v)
    );

    // ---------------- checking ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected output word {pclk, display_on, hsync, vsync, h[9:0], v[9:0]}
    // after n system clocks of normal running.
    function automatic logic [23:0] model(input int unsigned n, input int unsigned cd,
                                          input int unsigned hd, input int unsigned hf,
                                          input int unsigned hs, input int unsigned hb,
                                          input int unsigned vd, input int unsigned vf,
                                          input int unsigned vs, input int unsigned vb);
        int unsigned ht, vt, p, h, v;
        logic pc, de, hon, von, hsy, vsy;
        ht  = hd + hf + hs + hb;
        vt  = vd + vf + vs + vb;
        p   = n / cd;
        h   = p % ht;
        v   = (p / ht) % vt;
        pc  = (n % cd) >= (cd / 2);
        de  = (h < hd) && (v < vd);
        hon = (h >= hd + hf) && (h < hd + hf + hs);
        von = (v >= vd + vf) && (v < vd + vf + vs);
        hsy = hon ? SYNC_ON : ~SYNC_ON;
        vsy = von ? SYNC_ON : ~SYNC_ON;
        return {pc, de, hsy, vsy, h[9:0], v[9:0]};
    endfunction

    // ---------------- scoreboard ----------------
    logic [23:0]  exp_q[$];
    logic [23:0]  exp_s_q[$];
    int unsigned  cyc = 0;

    always @(posedge clk) begin
        if (!rst_n) cyc = 0;
        else        cyc = cyc + 1;
        exp_q.push_back(model(cyc, 4, 640, 16, 96, 48, 480, 10, 2, 33));
        exp_s_q.push_back(model(cyc, 4, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB));
    end

    always @(negedge clk) begin : sb_compare
        logic [23:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("full_vec", 32'({a_pc, a_de, a_hs, a_vs, a_h, a_v}), 32'(e));
        end
        if (exp_s_q.size() > 0) begin
            e = exp_s_q.pop_front();
            check("small_vec", 32'({b_pc, b_de, b_hs, b_vs, b_h, b_v}), 32'(e));
        end
    end

    // ---------------- directed sequence ----------------
    initial begin : main
        logic [23:0] rst_vec;
        int hs_cnt, pc_hi, vs_cnt;
        rst_vec = {1'b0, 1'b1, ~SYNC_ON, ~SYNC_ON, 10'd0, 10'd0};
        hs_cnt  = 0;
        pc_hi   = 0;
        vs_cnt  = 0;

        // Long reset hold: outputs must sit at reset values throughout.
        rst_n = 1'b0;
        repeat (20000) @(negedge clk);
        check("rst_hold_a", 32'({a_pc, a_de, a_hs, a_vs, a_h, a_v}), 32'(rst_vec));
        check("rst_hold_b", 32'({b_pc, b_de, b_hs, b_vs, b_h, b_v}), 32'(rst_vec));

        // Release and run exactly one full line of dut_a.
        #2 rst_n = 1'b1;
        for (int n = 1; n <= 3200; n++) begin
            @(negedge clk);
            if (a_hs == SYNC_ON) hs_cnt++;
            if (a_pc) pc_hi++;
            if (n <= 832 && b_vs == SYNC_ON) vs_cnt++;
            if (n == 2556) check("de_639_0",  32'(a_de), 32'd1);
            if (n == 2560) check("de_640_0",  32'(a_de), 32'd0);
            if (n == 32)   check("s_de_8_0",  32'(b_de), 32'd0);
            if (n == 348)  check("s_de_7_5",  32'(b_de), 32'd1);
            if (n == 384)  check("s_de_0_6",  32'(b_de), 32'd0);
            if (n == 831)  check("s_v_last",  32'({b_h, b_v}), 32'({10'd15, 10'd12}));
            if (n == 832)  check("s_v_wrap",  32'({b_h, b_v}), 32'({10'd0, 10'd0}));
        end
        check("hsync_clocks", 32'(hs_cnt), 32'd384);
        check("pclk_high",    32'(pc_hi),  32'd1600);
        check("s_vsync_clks", 32'(vs_cnt), 32'd128);
        check("line_wrap",    32'({a_h, a_v}), 32'({10'd0, 10'd1}));

        // Advance to h=300 on line 1, then reset asynchronously mid-pixel.
        repeat (1200) @(negedge clk);
        check("pos_300_1", 32'({a_h, a_v}), 32'({10'd300, 10'd1}));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_a", 32'({a_pc, a_de, a_hs, a_vs, a_h, a_v}), 32'(rst_vec));
        check("async_rst_b", 32'({b_pc, b_de, b_hs, b_vs, b_h, b_v}), 32'(rst_vec));
        repeat (3) @(negedge clk);

        // Restart from (0,0).
        #2 rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("restart_pos", 32'({a_h, a_v}), 32'({10'd25, 10'd0}));

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
